output_serializer: RTL
======================

# output_serializer

Parallel-to-serial transmitter that is the counterpart of `InputBuffer`. It accepts `DATA_WIDTH`-bit words, such as anomaly flags or scores from the isolation-tree datapath, over a valid/ready handshake. It shifts each word out MSB-first, one bit per enabled clock, in exactly the bit order `InputBuffer` captures. A one-word holding register lets upstream load the next word while the current one shifts, so frames can go out back-to-back.

## Interface
- `DATA_WIDTH`, 8: word width in bits, ≥2.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `data_input` input DATA_WIDTH: word to transmit.
- `data_valid` input 1: `data_input` is valid.
- `input_ready` output 1: holding register empty; a word transfers when `data_valid && input_ready` at a rising edge.
- `bit_enable` input 1: line advance enable; when low, the shifter holds its state.
- `serial_out` output 1: current serial bit.
- `serial_valid` output 1: `serial_out` carries a frame bit this cycle.
- `frame_done` output 1: one-cycle pulse coincident with the last bit of a frame.
- `busy` output 1: shifter is in a non-IDLE state or the holding register is full.

## Operation
- Datapath: holding register (`hold_data`, `hold_full`), shift register, bit counter of width `$clog2(DATA_WIDTH+1)`.
- `input_ready = !hold_full && reset`. It is combinational, and forced low while `reset` is low.
- Accept: on a handshake, `hold_data <= data_input` and `hold_full <= 1`.
- FSM states: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - If `hold_full` and `bit_enable` are both high: load the shifter from `hold_data`, clear `hold_full`, set counter = DATA_WIDTH-1, drive the MSB, and go to SHIFT.
  - If a handshake and a load happen in the same cycle, the load takes the old hold contents and the hold register takes the new word. Both are legal.
- SHIFT:
  - Each cycle with `bit_enable` high: shift left, drive the next bit, decrement the counter.
  - At counter 0, the current bit is the LSB and `frame_done` = 1.
  - Next state after the LSB:
    - Without parity: if `hold_full`, reload immediately and stay in SHIFT, giving no idle gap. Otherwise go to IDLE.
    - With parity: go to PARITY.
- `bit_enable` low in any state: outputs hold their values, `serial_valid` stays as it was, and `frame_done` is suppressed (it pulses only on an enabled last-bit cycle).
- Outputs in IDLE: `serial_out` = 0, `serial_valid` = 0.
- Reset low at any point, including mid-frame:
  - `hold_full` = 0, state = IDLE, counter = 0.
  - `serial_out` = 0, `serial_valid` = 0, `frame_done` = 0, `busy` = 0.
  - The partial frame is discarded and the held word is lost.

## Timing
- `serial_out`, `serial_valid`, `frame_done` and `busy` are registered.
- Latency when idle, with `bit_enable` constantly high:
  - Handshake at edge t.
  - Load at edge t+1; MSB is visible after t+1.
  - LSB is visible after edge t+DATA_WIDTH, with `frame_done` high in that same cycle.
- Back-to-back: the first bit of frame N+1 follows the LSB of frame N (or its parity bit) in the next enabled cycle.
- Throughput: one word per DATA_WIDTH enabled cycles, or DATA_WIDTH+1 with parity.
- `input_ready` rises in the cycle after the hold register is emptied into the shifter.

## Configuration
- `OUTPUT_SERIALIZER_PARITY_EN`:
  - Defined: after the LSB, the PARITY state drives one extra bit, the even parity (XOR of all data bits), with `serial_valid` = 1. `frame_done` moves to the parity cycle. Reload happens from PARITY.
  - Undefined: the PARITY state and the parity logic are absent. Frames are exactly DATA_WIDTH bits, directly compatible with `InputBuffer`.

## Structure
- Shared package `sensor_io_pkg`:
  - FSM state typedef `ser_state_t` (IDLE, SHIFT, PARITY).
  - `DEFAULT_DATA_WIDTH` = 8.
- One sub-module, `piso_shift_reg`: a parameterised load/shift register with enable, exposing its MSB.
- The FSM, counter and hold register live in the top level.

## Test plan
- Reset, then one word 8'hD5 with `bit_enable`=1 → `serial_out` sequence 1,1,0,1,0,1,0,1 on cycles t+1..t+8; `serial_valid` high for exactly 8 cycles; `frame_done` only on cycle t+8; `busy` low afterwards.
- Words 8'h33 then 8'hAA presented back-to-back → 16 contiguous valid bits 00110011 10101010; `input_ready` low only while the hold register is full; two `frame_done` pulses 8 cycles apart.
- Word 8'hF0 with `bit_enable` toggling 1,0,1,0 → the bit sequence is unchanged, each bit held across disabled cycles, and `frame_done` appears exactly once.
- Reset pulsed low for 1 cycle after the 3rd bit of 8'h33, with 8'hAA held → all outputs 0 in the next cycle; no further bits; `input_ready` high after reset is released.
- Loopback into `InputBuffer` (macro off) with 8'h5A and 8'h81 → `data_output` equals each word, and `data_ready` fires once per word.
- Macro on, word 8'h07 → 9 valid bits 00000111 followed by parity bit 1; `frame_done` on the 9th bit.

Source files
------------

// File: rtl/sensor_io_pkg.sv
// Shared types and defaults for the sensor serial I/O blocks.
// The PARITY state is only reachable when OUTPUT_SERIALIZER_PARITY_EN is defined.
package sensor_io_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register with load and shift enables.
// Shifts toward the MSB and exposes the MSB as the next bit to transmit.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] data_reg;

  // Load has priority over shift; zero is shifted into the LSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= {data_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = data_reg[WIDTH-1];

endmodule

// File: rtl/output_serializer.sv
// Parallel-to-serial transmitter: one-word holding register feeding an
// MSB-first shifter, one bit per enabled clock, with back-to-back frames.
// Optional feature: OUTPUT_SERIALIZER_PARITY_EN appends an even-parity bit.
module output_serializer
  import sensor_io_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  data_valid,
  output logic                  input_ready,
  input  logic                  bit_enable,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  ser_state_t            state, state_next;
  logic [CW-1:0]         count, count_next;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full, hold_full_next;
  logic                  serial_out_next;
  logic                  serial_valid_next;
  logic                  frame_done_next;
  logic                  busy_next;
  logic                  accept;
  logic                  load;
  logic                  shift;
  logic                  shift_msb;

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  logic parity_reg;
`endif

  assign input_ready = !hold_full && reset;
  assign accept      = data_valid && input_ready;

  // The shifter holds the bits still to be sent; the MSB goes straight to
  // serial_out at load time, so the shifter only needs the remaining bits.
  piso_shift_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .load_data({hold_data[DATA_WIDTH-2:0], 1'b0}),
    .msb      (shift_msb)
  );

  // Next-state and next-output logic; a disabled cycle holds everything.
  always_comb begin
    state_next        = state;
    count_next        = count;
    serial_out_next   = serial_out;
    serial_valid_next = serial_valid;
    frame_done_next   = 1'b0;
    load              = 1'b0;
    shift             = 1'b0;

    if (bit_enable) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            load = 1'b1;
          end
        end
        SHIFT: begin
          if (count == '0) begin
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            state_next        = PARITY;
            serial_out_next   = parity_reg;
            serial_valid_next = 1'b1;
            frame_done_next   = 1'b1;
`else
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_next        = IDLE;
              serial_out_next   = 1'b0;
              serial_valid_next = 1'b0;
            end
`endif
          end else begin
            shift           = 1'b1;
            serial_out_next = shift_msb;
            count_next      = count - CW'(1);
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            frame_done_next = 1'b0;
`else
            frame_done_next = (count == CW'(1));
`endif
          end
        end
`ifdef OUTPUT_SERIALIZER_PARITY_EN
        PARITY: begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_next        = IDLE;
            serial_out_next   = 1'b0;
            serial_valid_next = 1'b0;
          end
        end
`endif
        default: begin
          state_next        = IDLE;
          serial_out_next   = 1'b0;
          serial_valid_next = 1'b0;
        end
      endcase
    end

    // A load starts a new frame with its MSB, whatever state it came from.
    if (load) begin
      state_next        = SHIFT;
      count_next        = LAST_COUNT;
      serial_out_next   = hold_data[DATA_WIDTH-1];
      serial_valid_next = 1'b1;
    end

    hold_full_next = accept ? 1'b1 : (load ? 1'b0 : hold_full);
    busy_next      = (state_next != IDLE) || hold_full_next;
  end

  // State, counter, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      hold_full    <= hold_full_next;
      serial_out   <= serial_out_next;
      serial_valid <= serial_valid_next;
      frame_done   <= frame_done_next;
      busy         <= busy_next;
      if (accept) begin
        hold_data <= data_input;
      end
    end
  end

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  // Even parity of the word captured at load time, sent after its LSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^hold_data;
    end
  end
`endif

endmodule
